// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and types for the dmem arbiter.
// Port ids, default sizing and the read-return tag.
package dmem_arbiter_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEF_READ_LATENCY = 1;
  localparam int DEF_MAX_WAIT = 4;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } ret_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and dmem signals of the dmem arbiter.
// slave = arbiter side, master = requesters plus dmem.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arbiter_pkg::ADDR_W,
  parameter int DATA_W = dmem_arbiter_pkg::DATA_W
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_q,
    output gnt0, rvalid0, gnt1, rvalid1,
    output rdata, mem_address, mem_data,
    output mem_wren
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_q,
    input  gnt0, rvalid0, gnt1, rvalid1,
    input  rdata, mem_address, mem_data,
    input  mem_wren
  );
endinterface

// File: rtl/dmem_ret_pipe.sv
// Tracks granted reads through the syncram latency.
// Shift register of {valid, port}, async cleared.
module dmem_ret_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_READ_LATENCY
) (
  input  logic clock,
  input  logic reset,
  input  ret_t d,
  output ret_t q
);

  ret_t stage [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port dmem between CPU (port 0)
// and debug/loader (port 1) with a starvation guard.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = dmem_arbiter_pkg::ADDR_W,
  parameter int DATA_W       = dmem_arbiter_pkg::DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int MAX_WAIT     = DEF_MAX_WAIT
) (
  input  logic clock,
  input  logic reset,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_TOP = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt;
  logic              starve;
  logic              gnt0;
  logic              gnt1;
  logic              rv0;
  logic              rv1;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              wren;
  ret_t              ret_d;
  ret_t              ret_q;

  // Grants are masked during reset so nothing reaches dmem.
  assign starve = bus.req1 && (wait_cnt == WAIT_TOP);
  assign gnt1 = !reset && bus.req1 && (starve || !bus.req0);
  assign gnt0 = !reset && bus.req0 && !gnt1;

  always_comb begin
    addr  = '0;
    data  = '0;
    wren  = 1'b0;
    ret_d = '{valid: 1'b0, port: PORT_CPU};
    unique case (1'b1)
      gnt0: begin
        addr  = bus.addr0;
        data  = bus.wdata0;
        wren  = bus.we0;
        ret_d = '{valid: !bus.we0, port: PORT_CPU};
      end
      gnt1: begin
        addr  = bus.addr1;
        data  = bus.wdata1;
        wren  = bus.we1;
        ret_d = '{valid: !bus.we1, port: PORT_DBG};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (!bus.req1 || gnt1)
      wait_cnt <= '0;
    else if (wait_cnt != WAIT_TOP)
      wait_cnt <= wait_cnt + 4'd1;
  end

  dmem_ret_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_ret (
    .clock (clock),
    .reset (reset),
    .d     (ret_d),
    .q     (ret_q)
  );

  assign rv0 = ret_q.valid && (ret_q.port == PORT_CPU);
  assign rv1 = ret_q.valid && (ret_q.port == PORT_DBG);

  assign bus.gnt0        = gnt0;
  assign bus.gnt1        = gnt1;
  assign bus.mem_address = addr;
  assign bus.mem_data    = data;
  assign bus.mem_wren    = wren;
  assign bus.rvalid0     = rv0;
  assign bus.rvalid1     = rv1;
  assign bus.rdata       = (rv0 || rv1) ? bus.mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: dmem model, reference
// model with a due-cycle return queue, random traffic.
module tb_dmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int MW = 4;

  logic clock;
  logic reset;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  dmem_arbiter #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .READ_LATENCY (RL),
    .MAX_WAIT     (MW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // dmem syncram model with RL cycles of read latency
  logic [DW-1:0] mem [4096] = '{default: '0};
  logic [DW-1:0] qpipe [RL] = '{default: '0};

  always @(posedge clock) begin
    if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
    qpipe[0] <= mem[bus.mem_address];
    for (int i = 1; i < RL; i++) qpipe[i] <= qpipe[i-1];
  end

  assign bus.mem_q = qpipe[RL-1];

  // reference model
  typedef struct {
    int            due;
    bit            port;
    logic [DW-1:0] data;
  } ret_s;

  ret_s          pend[$];
  logic [DW-1:0] ref_mem [4096];
  int            cyc;
  int            wait_m;
  int            total;
  int            bad;
  bit            e_g0, e_g1, e_wren, e_rv0, e_rv1;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, e_rdata;

  task automatic tick(
    input bit r0, input bit w0,
    input logic [AW-1:0] a0, input logic [DW-1:0] d0,
    input bit r1, input bit w1,
    input logic [AW-1:0] a1, input logic [DW-1:0] d1
  );
    @(negedge clock);
    bus.req0 = r0; bus.we0 = w0;
    bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1;
    bus.addr1 = a1; bus.wdata1 = d1;
    #1;
    e_g1 = r1 && (wait_m == MW || !r0);
    e_g0 = r0 && !e_g1;
    e_wren = e_g0 ? w0 : (e_g1 ? w1 : 1'b0);
    e_addr = e_g0 ? a0 : (e_g1 ? a1 : '0);
    e_data = e_g0 ? d0 : (e_g1 ? d1 : '0);
    e_rv0 = 1'b0; e_rv1 = 1'b0; e_rdata = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e_rv0 = !pend[0].port;
      e_rv1 = pend[0].port;
      e_rdata = pend[0].data;
      void'(pend.pop_front());
    end
    if (e_g0 || e_g1) begin
      if (e_wren) ref_mem[e_addr] = e_data;
      else pend.push_back('{cyc + RL, e_g1, ref_mem[e_addr]});
    end
    if (r1 && !e_g1) wait_m = (wait_m < MW) ? wait_m + 1 : MW;
    else wait_m = 0;
    cyc++;
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b1;
    bus.addr0 = 12'h123; bus.wdata0 = 32'hCAFEF00D;
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    bus.addr1 = 12'h456; bus.wdata1 = '0;
    #3;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.mem_wren} !== 3'b000) begin
      bad++;
      $display("FAIL reset_gnt got=%b%b%b want=000",
        bus.gnt0, bus.gnt1, bus.mem_wren);
    end
    total++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00 || bus.rdata !== '0) begin
      bad++;
      $display("FAIL reset_ret got=%b%b/%h want=00/0",
        bus.rvalid0, bus.rvalid1, bus.rdata);
    end
    total++;
    if (bus.mem_address !== '0 || bus.mem_data !== '0) begin
      bad++;
      $display("FAIL reset_mem got=%h/%h want=0/0",
        bus.mem_address, bus.mem_data);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.req1 = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 4; k++) begin
      idle();
      total++;
      if ({bus.gnt0, bus.gnt1, bus.mem_wren} !== 3'b000 ||
          bus.mem_address !== '0 || bus.mem_data !== '0) begin
        bad++;
        $display("FAIL idle_bus k=%0d got=%b%b%b %h/%h want=000 0/0",
          k, bus.gnt0, bus.gnt1, bus.mem_wren,
          bus.mem_address, bus.mem_data);
      end
      total++;
      if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
        bad++;
        $display("FAIL idle_rv k=%0d got=%b%b want=00",
          k, bus.rvalid0, bus.rvalid1);
      end
    end
  endtask

  task automatic test_port0();
    int seen;
    seen = 0;
    tick(1'b1, 1'b1, 12'h010, 32'hDEADBEEF, 1'b0, 1'b0, '0, '0);
    total++;
    if (bus.gnt0 !== 1'b1 || bus.mem_wren !== 1'b1 ||
        bus.mem_address !== 12'h010 || bus.mem_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL p0_write got=%b%b %h/%h want=11 010/deadbeef",
        bus.gnt0, bus.mem_wren, bus.mem_address, bus.mem_data);
    end
    tick(1'b1, 1'b0, 12'h010, '0, 1'b0, 1'b0, '0, '0);
    total++;
    if (bus.gnt0 !== 1'b1 || bus.mem_wren !== 1'b0) begin
      bad++;
      $display("FAIL p0_read got=%b%b want=10", bus.gnt0, bus.mem_wren);
    end
    for (int k = 1; k <= RL + 1; k++) begin
      idle();
      total++;
      if (bus.rvalid0 !== (k == RL) || bus.rvalid1 !== 1'b0) begin
        bad++;
        $display("FAIL p0_rv k=%0d got=%b%b want=%b0",
          k, bus.rvalid0, bus.rvalid1, k == RL);
      end
      if (bus.rvalid0 === 1'b1) begin
        seen++;
        total++;
        if (bus.rdata !== 32'hDEADBEEF) begin
          bad++;
          $display("FAIL p0_rdata got=%h want=deadbeef", bus.rdata);
        end
      end
    end
    total++;
    if (seen != 1) begin
      bad++;
      $display("FAIL p0_count got=%0d want=1", seen);
    end
  endtask

  task automatic test_port1();
    tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'hFFF, 32'h12345678);
    total++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.mem_wren !== 1'b1) begin
      bad++;
      $display("FAIL p1_write got=%b%b%b want=011",
        bus.gnt0, bus.gnt1, bus.mem_wren);
    end
    tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'hFFF, '0);
    for (int k = 1; k <= RL + 1; k++) begin
      idle();
      total++;
      if (bus.rvalid1 !== (k == RL) || bus.rvalid0 !== 1'b0 ||
          bus.rdata !== ((k == RL) ? 32'h12345678 : 32'h0)) begin
        bad++;
        $display("FAIL p1_ret k=%0d got=%b%b/%h want=0%b",
          k, bus.rvalid0, bus.rvalid1, bus.rdata, k == RL);
      end
    end
  endtask

  task automatic test_contention();
    int n1;
    n1 = 0;
    idle();
    for (int k = 0; k < 15; k++) begin
      tick(1'b1, 1'b0, 12'(k), '0, 1'b1, 1'b0, 12'(k + 32), '0);
      total++;
      if (bus.gnt1 !== (k % 5 == 4) || bus.gnt0 !== (k % 5 != 4)) begin
        bad++;
        $display("FAIL cont_gnt k=%0d got=%b%b want=%b%b",
          k, bus.gnt0, bus.gnt1, k % 5 != 4, k % 5 == 4);
      end
      total++;
      if (bus.rvalid0 !== e_rv0 || bus.rvalid1 !== e_rv1 ||
          bus.rdata !== e_rdata) begin
        bad++;
        $display("FAIL cont_ret k=%0d got=%b%b/%h want=%b%b/%h",
          k, bus.rvalid0, bus.rvalid1, bus.rdata, e_rv0, e_rv1, e_rdata);
      end
      if (bus.gnt1 === 1'b1) n1++;
    end
    total++;
    if (n1 != 3) begin
      bad++;
      $display("FAIL cont_count got=%0d want=3", n1);
    end
    for (int k = 0; k < RL + 1; k++) begin
      idle();
      total++;
      if (bus.rvalid0 !== e_rv0 || bus.rvalid1 !== e_rv1 ||
          bus.rdata !== e_rdata) begin
        bad++;
        $display("FAIL cont_drain k=%0d got=%b%b/%h want=%b%b/%h",
          k, bus.rvalid0, bus.rvalid1, bus.rdata, e_rv0, e_rv1, e_rdata);
      end
    end
  endtask

  task automatic test_interleave();
    int c0, c1, c;
    logic [DW-1:0] d0, d1;
    c0 = -1; c1 = -1; c = 0;
    tick(1'b1, 1'b1, 12'h001, 32'hA1A1A1A1, 1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b1, 12'h002, 32'hB2B2B2B2, 1'b0, 1'b0, '0, '0);
    tick(1'b1, 1'b0, 12'h001, '0, 1'b0, 1'b0, '0, '0);
    tick(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'h002, '0);
    for (int k = 0; k < RL + 2; k++) begin
      idle();
      c++;
      if (bus.rvalid0 === 1'b1) begin c0 = c; d0 = bus.rdata; end
      if (bus.rvalid1 === 1'b1) begin c1 = c; d1 = bus.rdata; end
    end
    total++;
    if (c0 != RL - 1 || c1 != RL) begin
      bad++;
      $display("FAIL ilv_timing got=%0d,%0d want=%0d,%0d",
        c0, c1, RL - 1, RL);
    end
    total++;
    if (d0 !== 32'hA1A1A1A1 || d1 !== 32'hB2B2B2B2) begin
      bad++;
      $display("FAIL ilv_data got=%h,%h want=a1a1a1a1,b2b2b2b2", d0, d1);
    end
  endtask

  task automatic test_random();
    bit p0, p1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    p0 = 0; p1 = 0; w0 = 0; w1 = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int k = 0; k < 400; k++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1; w0 = 1'($urandom_range(0, 1));
        a0 = 12'($urandom_range(0, 15)); d0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 1) != 0) begin
        p1 = 1; w1 = 1'($urandom_range(0, 1));
        a1 = 12'($urandom_range(0, 15)); d1 = $urandom;
      end
      tick(p0, w0, a0, d0, p1, w1, a1, d1);
      total++;
      if (bus.gnt0 !== e_g0 || bus.gnt1 !== e_g1 ||
          bus.mem_wren !== e_wren || bus.mem_address !== e_addr ||
          bus.mem_data !== e_data) begin
        bad++;
        $display("FAIL rnd_bus k=%0d got=%b%b%b %h/%h want=%b%b%b %h/%h",
          k, bus.gnt0, bus.gnt1, bus.mem_wren, bus.mem_address,
          bus.mem_data, e_g0, e_g1, e_wren, e_addr, e_data);
      end
      total++;
      if (bus.rvalid0 !== e_rv0 || bus.rvalid1 !== e_rv1 ||
          bus.rdata !== e_rdata) begin
        bad++;
        $display("FAIL rnd_ret k=%0d got=%b%b/%h want=%b%b/%h",
          k, bus.rvalid0, bus.rvalid1, bus.rdata, e_rv0, e_rv1, e_rdata);
      end
      if (e_g0) p0 = 0;
      if (e_g1) p1 = 0;
    end
    for (int k = 0; k < RL + 1; k++) begin
      idle();
      total++;
      if (bus.rvalid0 !== e_rv0 || bus.rvalid1 !== e_rv1 ||
          bus.rdata !== e_rdata) begin
        bad++;
        $display("FAIL rnd_drain k=%0d got=%b%b/%h want=%b%b/%h",
          k, bus.rvalid0, bus.rvalid1, bus.rdata, e_rv0, e_rv1, e_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 12'h005, '0, 1'b0, 1'b0, '0, '0);
    total++;
    if (bus.gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL rmid_gnt got=%b want=1", bus.gnt0);
    end
    @(posedge clock);
    #1;
    bus.req0 = 1'b1; bus.we0 = 1'b1;
    bus.addr0 = 12'h0AA; bus.wdata0 = 32'h5A5A5A5A;
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.gnt0, bus.gnt1, bus.mem_wren} !== 3'b000 ||
        {bus.rvalid0, bus.rvalid1} !== 2'b00) begin
      bad++;
      $display("FAIL rmid_now got=%b%b%b %b%b want=000 00",
        bus.gnt0, bus.gnt1, bus.mem_wren, bus.rvalid0, bus.rvalid1);
    end
    pend.delete();
    wait_m = 0;
    @(posedge clock);
    #1;
    total++;
    if ({bus.rvalid0, bus.rvalid1} !== 2'b00 || bus.rdata !== '0) begin
      bad++;
      $display("FAIL rmid_hold got=%b%b/%h want=00/0",
        bus.rvalid0, bus.rvalid1, bus.rdata);
    end
    @(negedge clock);
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.req1 = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < RL + 2; k++) begin
      idle();
      total++;
      if ({bus.rvalid0, bus.rvalid1} !== 2'b00) begin
        bad++;
        $display("FAIL rmid_after k=%0d got=%b%b want=00",
          k, bus.rvalid0, bus.rvalid1);
      end
    end
  endtask

  initial begin
    clock = 1'b0;
    total = 0; bad = 0; cyc = 0; wait_m = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    test_reset();
    test_idle();
    test_port0();
    test_port1();
    test_contention();
    test_interleave();
    test_random();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
